// File: rtl/core_inst_sequencer.sv
// Instruction sequencer for the core datapath. It emits one 62-bit
// instruction word per cycle for a full convolution pass. For each kernel
// index it loads weights, loads activations, executes, and drains the
// output FIFO into psum SRAM. It then runs one accumulate sweep into the
// final SRAM.
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-low reset
//   start        one-cycle pulse, accepted only in IDLE
//   ofifo_valid  core output FIFO holds a full column vector
//   inst         registered core instruction word
//   busy         high while a pass is in progress
//   done         one-cycle pulse when a pass completes (or aborts on timeout)
//   err          sticky drain-timeout flag, cleared by reset or the next start
//   kij_idx      current kernel index
module core_inst_sequencer #(
  parameter  int unsigned LEN_KIJ       = 9,
  parameter  int unsigned LEN_NIJ       = 36,
  parameter  int unsigned LEN_ONIJ      = 16,
  parameter  int unsigned ROW           = 8,
  parameter  int unsigned W_BASE        = 1024,
  parameter  int unsigned DRAIN_TIMEOUT = 255,
  localparam int unsigned INST_W        = 62,
  localparam int unsigned KIJ_W         = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [KIJ_W-1:0]  kij_idx
);

  // Field widths and bit positions of the instruction word
  localparam int unsigned XA_W       = 11;
  localparam int unsigned PA_W       = 12;
  localparam int unsigned FA_W       = 11;
  localparam int unsigned CNT_W      = $clog2(LEN_NIJ + 2);
  localparam int unsigned STALL_W    = $clog2(DRAIN_TIMEOUT + 1);
  localparam int unsigned B_KLOAD    = 0;
  localparam int unsigned B_EXEC     = 1;
  localparam int unsigned B_L0_WR    = 2;
  localparam int unsigned B_L0_RD    = 3;
  localparam int unsigned B_OFIFO_RD = 6;
  localparam int unsigned XA_LSB     = 7;
  localparam int unsigned B_XWEN     = 18;
  localparam int unsigned B_XCEN     = 19;
  localparam int unsigned PWA_LSB    = 20;
  localparam int unsigned B_PWEN     = 32;
  localparam int unsigned B_PCEN     = 33;
  localparam int unsigned B_ACC      = 34;
  localparam int unsigned FA_LSB     = 35;
  localparam int unsigned B_FWEN     = 46;
  localparam int unsigned B_FCEN     = 47;
  localparam int unsigned B_CEN_ACT  = 48;
  localparam int unsigned B_PCEN_RD  = 49;
  localparam int unsigned PRA_LSB    = 50;

  // Accumulate map geometry: 3x3 kernel sliding over a 6x6 input -> 4x4 output
  localparam int unsigned IN_DIM = 6;
  localparam int unsigned K_DIM  = 3;
  localparam int unsigned O_DIM  = IN_DIM - K_DIM + 1;

  localparam logic [INST_W-1:0] IDLE_WORD =
      (INST_W'(1) << B_XWEN) | (INST_W'(1) << B_XCEN) |
      (INST_W'(1) << B_PWEN) | (INST_W'(1) << B_PCEN) |
      (INST_W'(1) << B_FWEN) | (INST_W'(1) << B_FCEN) |
      (INST_W'(1) << B_CEN_ACT) | (INST_W'(1) << B_PCEN_RD);

  // psum write addresses must never wrap
  if (LEN_KIJ * LEN_NIJ > 4096) begin : g_psum_range_chk
    $error("core_inst_sequencer: LEN_KIJ*LEN_NIJ exceeds psum address space");
  end
  if (LEN_NIJ != IN_DIM * IN_DIM || LEN_ONIJ != O_DIM * O_DIM ||
      LEN_KIJ != K_DIM * K_DIM) begin : g_geom_chk
    $error("core_inst_sequencer: accumulate map assumes 3x3 kernel over 6x6 input");
  end

  typedef enum logic [2:0] {
    IDLE, W_LOAD, W_PUSH, X_LOAD, EXEC, DRAIN, ACC, FIN
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [STALL_W-1:0]  stall, stall_d;
  logic [KIJ_W-1:0]    kij_d;
  logic [1:0]          k_row, k_row_d, k_col, k_col_d;
  logic [1:0]          o_row, o_row_d, o_col, o_col_d;
  logic                wr_pend, wr_pend_d;
  logic [PA_W-1:0]     wr_addr, wr_addr_d;
  logic                fin_pend, fin_pend_d;
  logic [FA_W-1:0]     fin_addr, fin_addr_d;
  logic                err_d;
  logic [INST_W-1:0]   inst_c;

  // Next-state, counters and instruction word
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    stall_d    = stall;
    kij_d      = kij_idx;
    k_row_d    = k_row;
    k_col_d    = k_col;
    o_row_d    = o_row;
    o_col_d    = o_col;
    wr_pend_d  = 1'b0;
    wr_addr_d  = wr_addr;
    fin_pend_d = 1'b0;
    fin_addr_d = fin_addr;
    err_d      = err;
    inst_c     = IDLE_WORD;

    // SRAM writes trail the read that produced their data by one cycle,
    // so they are driven from pending registers regardless of state
    if (wr_pend) begin
      inst_c[B_PCEN] = 1'b0;
      inst_c[B_PWEN] = 1'b0;
      inst_c[PWA_LSB +: PA_W] = wr_addr;
    end
    if (fin_pend) begin
      inst_c[B_FCEN] = 1'b0;
      inst_c[B_FWEN] = 1'b0;
      inst_c[FA_LSB +: FA_W] = fin_addr;
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_d = W_LOAD;
          cnt_d   = '0;
          stall_d = '0;
          kij_d   = '0;
          k_row_d = '0;
          k_col_d = '0;
          o_row_d = '0;
          o_col_d = '0;
          err_d   = 1'b0;
        end
      end
      // l0_wr lags the xmem read by one cycle, hence the extra cycle
      W_LOAD: begin
        if (cnt < CNT_W'(ROW)) begin
          inst_c[B_XCEN] = 1'b0;
          inst_c[XA_LSB +: XA_W] = XA_W'(W_BASE + 32'(kij_idx) * ROW + 32'(cnt));
        end
        inst_c[B_L0_WR] = (cnt != '0);
        if (cnt == CNT_W'(ROW)) begin
          cnt_d   = '0;
          state_d = W_PUSH;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      W_PUSH: begin
        inst_c[B_L0_RD] = 1'b1;
        inst_c[B_KLOAD] = 1'b1;
        if (cnt == CNT_W'(ROW - 1)) begin
          cnt_d   = '0;
          state_d = X_LOAD;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      // Activation fetch also enables the activation-side SRAM select
      X_LOAD: begin
        if (cnt < CNT_W'(LEN_NIJ)) begin
          inst_c[B_XCEN]    = 1'b0;
          inst_c[B_CEN_ACT] = 1'b0;
          inst_c[XA_LSB +: XA_W] = XA_W'(cnt);
        end
        inst_c[B_L0_WR] = (cnt != '0);
        if (cnt == CNT_W'(LEN_NIJ)) begin
          cnt_d   = '0;
          state_d = EXEC;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      EXEC: begin
        inst_c[B_L0_RD] = 1'b1;
        inst_c[B_EXEC]  = 1'b1;
        if (cnt == CNT_W'(LEN_NIJ - 1)) begin
          cnt_d   = '0;
          stall_d = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      // Pop one vector per valid cycle; an empty FIFO stalls the count
      DRAIN: begin
        if (ofifo_valid) begin
          inst_c[B_OFIFO_RD] = 1'b1;
          wr_pend_d = 1'b1;
          wr_addr_d = PA_W'(32'(kij_idx) * LEN_NIJ + 32'(cnt));
          stall_d   = '0;
          if (cnt == CNT_W'(LEN_NIJ - 1)) begin
            cnt_d   = '0;
            kij_d   = kij_idx + KIJ_W'(1);
            state_d = ((32'(kij_idx) + 32'd1) < LEN_KIJ) ? W_LOAD : ACC;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end else if (stall == STALL_W'(DRAIN_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          stall_d = stall + STALL_W'(1);
        end
      end
      // Walk kij (inner) for each output pixel, reading the matching psum
      ACC: begin
        inst_c[B_ACC]     = 1'b1;
        inst_c[B_PCEN_RD] = 1'b0;
        inst_c[PRA_LSB +: PA_W] = PA_W'(
            (32'(k_row) * K_DIM + 32'(k_col)) * LEN_NIJ +
            (32'(o_row) + 32'(k_row)) * IN_DIM + 32'(o_col) + 32'(k_col));
        if (k_col == 2'(K_DIM - 1)) begin
          k_col_d = '0;
          if (k_row == 2'(K_DIM - 1)) begin
            k_row_d    = '0;
            fin_pend_d = 1'b1;
            fin_addr_d = FA_W'(32'(o_row) * O_DIM + 32'(o_col));
            if (o_col == 2'(O_DIM - 1)) begin
              o_col_d = '0;
              if (o_row == 2'(O_DIM - 1)) begin
                o_row_d = '0;
                state_d = FIN;
              end else begin
                o_row_d = o_row + 2'd1;
              end
            end else begin
              o_col_d = o_col + 2'd1;
            end
          end else begin
            k_row_d = k_row + 2'd1;
          end
        end else begin
          k_col_d = k_col + 2'd1;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      stall    <= '0;
      kij_idx  <= '0;
      k_row    <= '0;
      k_col    <= '0;
      o_row    <= '0;
      o_col    <= '0;
      wr_pend  <= 1'b0;
      wr_addr  <= '0;
      fin_pend <= 1'b0;
      fin_addr <= '0;
      err      <= 1'b0;
      inst     <= IDLE_WORD;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      stall    <= stall_d;
      kij_idx  <= kij_d;
      k_row    <= k_row_d;
      k_col    <= k_col_d;
      o_row    <= o_row_d;
      o_col    <= o_col_d;
      wr_pend  <= wr_pend_d;
      wr_addr  <= wr_addr_d;
      fin_pend <= fin_pend_d;
      fin_addr <= fin_addr_d;
      err      <= err_d;
      inst     <= inst_c;
      // busy drops on the same edge that raises done
      busy     <= (state_d != IDLE);
      done     <= (state == FIN);
    end
  end

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Directed bench for core_inst_sequencer: reset values, full pass address
// streams, abort on reset, stalled/toggled drain, drain timeout and err clear.
module tb_core_inst_sequencer;

  localparam logic [61:0] IDLE_WORD = 62'h3C003000C0000;

  logic        clk;
  logic        reset;
  logic        start;
  logic        ofifo_valid;
  logic [61:0] inst;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  kij_idx;

  int checks = 0;
  int errors = 0;

  // Event log filled by the negedge monitor
  int          cyc = 0;
  int          clr_epoch = 0;
  int          seen_epoch = 0;
  logic [10:0] xq[$];
  logic [11:0] pq[$];
  logic [11:0] rq[$];
  logic [10:0] fq[$];
  int          rd_cnt = 0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          viol = 0;
  int          last_wr_cyc = 0;
  int          done_cyc = 0;
  int          busy_rise_cyc = 0;
  logic        prev_rd = 1'b0;
  logic        prev_busy = 1'b0;
  logic        psum_wr;

  core_inst_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .kij_idx     (kij_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (clr_epoch != seen_epoch) begin
      seen_epoch = clr_epoch;
      xq.delete(); pq.delete(); rq.delete(); fq.delete();
      rd_cnt = 0; acc_cnt = 0; done_cnt = 0; viol = 0;
      last_wr_cyc = 0; done_cyc = 0; busy_rise_cyc = 0;
    end
    if (reset) begin
      if (!inst[19]) xq.push_back(inst[17:7]);
      psum_wr = !inst[33] && !inst[32];
      if (psum_wr) begin
        pq.push_back(inst[31:20]);
        last_wr_cyc = cyc;
      end
      if (psum_wr != prev_rd) viol++;
      prev_rd = inst[6];
      if (inst[6]) rd_cnt++;
      if (!inst[49]) begin
        rq.push_back(inst[61:50]);
        if (!inst[34]) viol++;
      end
      if (inst[34]) acc_cnt++;
      if (!inst[47] && !inst[46]) fq.push_back(inst[45:35]);
      if (busy && !prev_busy) busy_rise_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy || !prev_busy) viol++;
      end
      prev_busy = busy;
    end else begin
      prev_rd   = 1'b0;
      prev_busy = 1'b0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr_epoch = clr_epoch + 1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int xbad;
    int pbad;
    int fbad;
    int idx;
    int exp_a;

    reset = 1'b1;
    start = 1'b0;
    ofifo_valid = 1'b0;
    #3 reset = 1'b0;
    step();
    step();

    // Reset values
    check("rst_inst", 64'(inst), 64'(IDLE_WORD));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_kij", 64'(kij_idx), 64'd0);

    // Full pass with the FIFO always ready, plus an ignored restart in W_PUSH
    reset = 1'b1;
    step();
    clear_mon();
    ofifo_valid = 1'b1;
    start = 1'b1;
    step();
    check("pass_busy_rise", 64'(busy), 64'd1);
    start = 1'b0;
    step();
    check("pass_first_xcen", 64'(inst[19]), 64'd0);
    check("pass_first_xa", 64'(inst[17:7]), 64'd1024);
    for (int i = 0; i < 50; i++) begin
      step();
      if (inst[0]) break;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (done_cnt != 0) break;
    end
    for (int i = 0; i < 5; i++) step();

    check("pass_done_cnt", 64'(done_cnt), 64'd1);
    check("pass_length", 64'(done_cyc - busy_rise_cyc), 64'd1279);
    check("pass_xq_size", 64'(xq.size()), 64'd396);
    xbad = 0;
    for (int k = 0; k < 9; k++) begin
      for (int j = 0; j < 44; j++) begin
        idx = k * 44 + j;
        exp_a = (j < 8) ? (1024 + k * 8 + j) : (j - 8);
        if (idx < xq.size()) begin
          if (xq[idx] != 11'(exp_a)) xbad++;
        end
      end
    end
    check("pass_xmem_addrs", 64'(xbad), 64'd0);
    check("pass_kij1_w_first", (xq.size() > 51) ? 64'(xq[44]) : '1, 64'd1032);
    check("pass_kij1_w_last", (xq.size() > 51) ? 64'(xq[51]) : '1, 64'd1039);
    check("pass_pq_size", 64'(pq.size()), 64'd324);
    pbad = 0;
    for (int i = 0; i < pq.size(); i++) begin
      if (pq[i] != 12'(i)) pbad++;
    end
    check("pass_psum_addrs", 64'(pbad), 64'd0);
    check("pass_kij2_first", (pq.size() > 107) ? 64'(pq[72]) : '1, 64'd72);
    check("pass_kij2_last", (pq.size() > 107) ? 64'(pq[107]) : '1, 64'd107);
    check("pass_ofifo_rd", 64'(rd_cnt), 64'd324);
    check("pass_acc_reads", 64'(rq.size()), 64'd144);
    check("pass_acc_cycles", 64'(acc_cnt), 64'd144);
    check("pass_rd_a1", (rq.size() > 143) ? 64'(rq[1]) : '1, 64'd37);
    check("pass_rd_a49", (rq.size() > 143) ? 64'(rq[49]) : '1, 64'd158);
    check("pass_rd_a143", (rq.size() > 143) ? 64'(rq[143]) : '1, 64'd323);
    check("pass_fq_size", 64'(fq.size()), 64'd16);
    fbad = 0;
    for (int i = 0; i < fq.size(); i++) begin
      if (fq[i] != 11'(i)) fbad++;
    end
    check("pass_final_addrs", 64'(fbad), 64'd0);
    check("pass_viol", 64'(viol), 64'd0);
    check("pass_err", 64'(err), 64'd0);
    check("pass_busy_end", 64'(busy), 64'd0);
    check("pass_kij_end", 64'(kij_idx), 64'd9);

    // Reset asserted during the kij=1 EXEC phase
    clear_mon();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (inst[1] && kij_idx == 4'd1) break;
    end
    check("abort_in_exec", 64'(inst[1]), 64'd1);
    reset = 1'b0;
    step();
    check("abort_inst", 64'(inst), 64'(IDLE_WORD));
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_kij", 64'(kij_idx), 64'd0);
    reset = 1'b1;
    step();
    check("abort_post_inst", 64'(inst), 64'(IDLE_WORD));
    check("abort_done_cnt", 64'(done_cnt), 64'd0);

    // Toggled FIFO in kij=0 drain, then a starved kij=1 drain
    clear_mon();
    ofifo_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (pq.size() >= 36) break;
      ofifo_valid = ~ofifo_valid;
    end
    ofifo_valid = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (done_cnt != 0) break;
    end
    for (int i = 0; i < 3; i++) step();
    check("tog_pq_size", 64'(pq.size()), 64'd36);
    pbad = 0;
    for (int i = 0; i < pq.size(); i++) begin
      if (pq[i] != 12'(i)) pbad++;
    end
    check("tog_psum_addrs", 64'(pbad), 64'd0);
    check("tog_viol", 64'(viol), 64'd0);
    check("tmo_done_cnt", 64'(done_cnt), 64'd1);
    check("tmo_latency", 64'(done_cyc - last_wr_cyc), 64'd345);
    check("tmo_err", 64'(err), 64'd1);
    check("tmo_kij", 64'(kij_idx), 64'd1);
    check("tmo_no_final", 64'(fq.size()), 64'd0);
    check("tmo_busy", 64'(busy), 64'd0);

    // Next accepted start clears the sticky error
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_err_clr", 64'(err), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_inst_sequencer.md
Name: core_inst_sequencer

Overview:
- Upstream instruction generator for the core datapath; produces the 62-bit inst word every cycle.
- Sequences one full convolution pass: per kernel index kij, load weights, load activations, execute, drain ofifo into psum SRAM; then one accumulate sweep into the final SRAM.
- Replaces testbench-driven instruction streams.
- Reacts only to start and to ofifo_valid coming back from the core.

Parameters:
- len_kij, 9, kernel positions per pass
- len_nij, 36, input activations per kij
- len_onij, 16, output pixels accumulated in final sweep
- row, 8, weight vectors per kij (array rows)
- w_base, 1024, xmem base address of kij-0 weights; kij k weights at w_base + k*row
- drain_timeout, 255, max cycles waiting for ofifo_valid before error

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; accepted only in IDLE
- ofifo_valid  input  1  core output FIFO holds a full column-vector
- inst  output  62  core instruction word
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse on pass completion
- err  output  1  sticky drain-timeout flag; cleared by reset or next accepted start
- kij_idx  output  4  current kernel index

Behaviour:
- Instruction field map (all outputs registered, one cycle after state/counter update):
  - inst[1:0] = {execute, kernel_load}; inst[2] = l0_wr; inst[3] = l0_rd; inst[6] = ofifo_rd
  - inst[17:7] = xmem A; inst[18] = xmem WEN; inst[19] = xmem CEN; inst[48] = CEN_act
  - inst[31:20] = psum write A; inst[32] = psum WEN; inst[33] = psum CEN
  - inst[34] = acc; inst[49] = psum CEN_rd; inst[61:50] = psum read A
  - inst[45:35] = final A; inst[46] = final WEN; inst[47] = final CEN
- All CEN/WEN bits are active-low.
- Idle word: all CEN/WEN = 1, every other bit 0.
- Reset: inst = idle word; busy, done, err = 0; kij_idx = 0; state IDLE; all counters 0.
- Reset mid-pass: abort immediately to reset values. No partial SRAM write may follow the deassertion edge.
- FSM states: IDLE, W_LOAD, W_PUSH, X_LOAD, EXEC, DRAIN, ACC, FIN.
  - IDLE -> W_LOAD on start; clears err, kij_idx, counters.
  - W_LOAD (row cycles): CEN=0, WEN=1, A = w_base + kij*row + cnt, l0_wr=1. l0_wr lags A by one cycle to cover SRAM read latency (row+1 cycles total).
  - W_PUSH (row cycles): l0_rd=1, kernel_load=1.
  - X_LOAD (len_nij+1 cycles): A = cnt from 0, same CEN/l0_wr timing as W_LOAD.
  - EXEC (len_nij cycles): l0_rd=1, execute=1.
  - DRAIN (len_nij vectors):
    - Each cycle ofifo_valid=1 -> ofifo_rd=1.
    - Next cycle: psum CEN=0, WEN=0, A = kij*len_nij + vector count.
    - ofifo_valid=0 stalls without advancing the count.
    - drain_timeout consecutive stall cycles -> err=1, go to FIN.
  - After DRAIN: kij_idx += 1. If kij_idx < len_kij -> W_LOAD; else -> ACC.
  - ACC (len_onij*len_kij read cycles):
    - CEN_rd=0, acc=1, read A from the sequencer's o-to-nij map.
    - The map is a ROM-free counter: row/col offset by kij for 3x3 kernel over 6x6 input.
    - Final SRAM written once per output (CEN=0, WEN=0, A = onij) on the cycle after the last kij read of that output.
  - FIN: done=1 for one cycle -> IDLE.
- start while busy: ignored.
- Address widths: psum write address is 12 bits; wrap modulo 4096 is forbidden by construction (len_kij*len_nij <= 4096, checked by an elaboration-time assertion).

Test Plan:
- Reset low mid-EXEC -> next cycle inst = idle word (bits 19, 18, 33, 32, 47, 46, 48, 49 = 1, others 0); busy=0; kij_idx=0.
- start with ofifo_valid held high after EXEC -> W_LOAD xmem A sequence 1024..1031 for kij=0, 1032..1039 for kij=1; 9 kij loops; done pulse exactly once; busy falls on the same cycle done rises.
- kij=2 DRAIN -> psum write addresses 72..107, WEN=0 only on the cycles after ofifo_rd.
- ofifo_valid toggled 1/0 every cycle in DRAIN -> 36 writes still issued; no address skipped or repeated.
- ofifo_valid held 0 for 255 cycles in DRAIN -> err=1, done pulse, IDLE; next start clears err.
- Second start pulse during W_PUSH -> ignored; total done count after both = 1.
- ACC phase -> exactly 16 final SRAM writes, A = 0..15 in order; acc=1 throughout, 144 read cycles.
